// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with hold/shift/load and an autonomous N-shift burst engine
module shift_reg_univ #(
  parameter int          WIDTH     = 8,
  parameter int          CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             burst_left;
  logic             burst_rot;

  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v, input logic rot, input logic s);
    return {rot ? v[0] : s, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v, input logic rot, input logic s);
    return {v[WIDTH-2:0], rot ? v[WIDTH-1] : s};
  endfunction

  assign q_ = ~q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RESET_VAL;
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      burst_left <= 1'b0;
      burst_rot  <= 1'b0;
    end else begin
      // done is a single-cycle pulse even when en is low
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start && (mode == MODE_SHR || mode == MODE_SHL)) begin
              burst_left <= (mode == MODE_SHL);
              burst_rot  <= rotate;
              cnt        <= len;
              if (len != '0) begin
                state <= BUSY;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end else begin
              case (mode)
                MODE_SHR:  q <= shr(q, rotate, sin_r);
                MODE_SHL:  q <= shl(q, rotate, sin_l);
                MODE_LOAD: q <= d;
                MODE_HOLD: q <= q;
                default:   q <= q;
              endcase
            end
          end
          BUSY: begin
            q   <= burst_left ? shl(q, burst_rot, sin_l) : shr(q, burst_rot, sin_r);
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - directed self-checking bench for shift_reg_univ
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       rotate;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] d;
  logic       start;
  logic [3:0] len;
  logic [7:0] q;
  logic [7:0] q_;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  shift_reg_univ #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rotate(rotate),
    .sin_r(sin_r), .sin_l(sin_l), .d(d), .start(start), .len(len),
    .q(q), .q_(q_), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 2'b11; d = v; start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    load(8'h3C);
    n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL pre_reset_load q=%h exp=3c", q); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q q=%h exp=00", q); end
    n_checks++; if (q_ !== 8'hFF) begin n_fail++; $display("FAIL reset_qn q_=%h exp=ff", q_); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b done=%b exp=0 0", busy, done); end
    #1 rst_n = 1'b1;
    en = 1'b0; mode = 2'b11; d = 8'h77;
    repeat (3) tick();
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_en0_hold q=%h exp=00", q); end
  endtask

  task automatic test_load_hold();
    load(8'hA5);
    n_checks++; if (q !== 8'hA5 || q_ !== 8'h5A) begin n_fail++; $display("FAIL load q=%h q_=%h exp=a5 5a", q, q_); end
    en = 1'b0; d = 8'hFF;
    tick();
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL hold_en0 q=%h exp=a5", q); end
  endtask

  task automatic test_shifts();
    en = 1'b1; mode = 2'b01; rotate = 1'b0; sin_r = 1'b1;
    tick();
    n_checks++; if (q !== 8'hD2) begin n_fail++; $display("FAIL shr_sin q=%h exp=d2", q); end
    load(8'h81);
    mode = 2'b10; rotate = 1'b1; sin_l = 1'b0;
    tick();
    n_checks++; if (q !== 8'h03) begin n_fail++; $display("FAIL shl_rot q=%h exp=03", q); end
    mode = 2'b01; rotate = 1'b1; sin_r = 1'b0;
    tick();
    n_checks++; if (q !== 8'h81) begin n_fail++; $display("FAIL shr_rot q=%h exp=81", q); end
  endtask

  task automatic test_burst(input bit stall);
    logic [7:0] exp_q [3] = '{8'h02, 8'h04, 8'h08};
    int busy_cycles = 0;
    int idx = 0;
    int cyc = 0;
    bit got_done = 1'b0;
    load(8'h01);
    mode = 2'b10; rotate = 1'b0; sin_l = 1'b0; start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0; mode = 2'b11; d = 8'hEE;
    n_checks++; if (q !== 8'h01 || busy !== 1'b1) begin n_fail++; $display("FAIL burst_accept q=%h busy=%b exp=01 1", q, busy); end
    busy_cycles = 1;
    while (!got_done && cyc < 20) begin
      en = !(stall && cyc == 1);
      tick();
      cyc++;
      if (en) begin
        n_checks++; if (idx < 3 && q !== exp_q[idx]) begin n_fail++; $display("FAIL burst_step%0d q=%h exp=%h", idx, q, exp_q[idx]); end
        idx++;
      end
      if (busy) busy_cycles++;
      got_done = done;
    end
    en = 1'b1;
    n_checks++; if (!got_done) begin n_fail++; $display("FAIL burst_timeout done=0 exp=1"); end
    n_checks++; if (busy_cycles != (stall ? 4 : 3)) begin n_fail++; $display("FAIL burst_busy_len got=%0d exp=%0d", busy_cycles, stall ? 4 : 3); end
    n_checks++; if (q !== 8'h08 || busy !== 1'b0) begin n_fail++; $display("FAIL burst_final q=%h busy=%b exp=08 0", q, busy); end
    mode = 2'b00;
    tick();
    n_checks++; if (done !== 1'b0 || q !== 8'h08) begin n_fail++; $display("FAIL burst_done_clear done=%b q=%h exp=0 08", done, q); end
  endtask

  task automatic test_boundaries();
    en = 1'b1; mode = 2'b10; start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0; mode = 2'b00;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h08) begin n_fail++; $display("FAIL len0 done=%b busy=%b q=%h exp=1 0 08", done, busy, q); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_after done=%b busy=%b exp=0 0", done, busy); end
    mode = 2'b11; d = 8'h5A; start = 1'b1; len = 4'd3;
    tick();
    n_checks++; if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL start_load q=%h busy=%b done=%b exp=5a 0 0", q, busy, done); end
    mode = 2'b01; rotate = 1'b0; sin_r = 1'b0; start = 1'b1; len = 4'd2;
    tick();
    mode = 2'b10; len = 4'd7; sin_l = 1'b1;
    tick();
    n_checks++; if (q !== 8'h2D || busy !== 1'b1) begin n_fail++; $display("FAIL busy_ignore1 q=%h busy=%b exp=2d 1", q, busy); end
    tick();
    start = 1'b0; mode = 2'b00;
    n_checks++; if (q !== 8'h16 || busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL busy_ignore2 q=%h busy=%b done=%b exp=16 0 1", q, busy, done); end
    tick();
    n_checks++; if (done !== 1'b0 || q !== 8'h16) begin n_fail++; $display("FAIL busy_ignore3 done=%b q=%h exp=0 16", done, q); end
  endtask

  task automatic test_reset_mid_burst();
    load(8'h01);
    mode = 2'b10; rotate = 1'b0; sin_l = 1'b0; start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0; mode = 2'b00;
    repeat (2) tick();
    n_checks++; if (q !== 8'h04 || busy !== 1'b1) begin n_fail++; $display("FAIL midburst_pre q=%h busy=%b exp=04 1", q, busy); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midburst_reset q=%h busy=%b done=%b exp=00 0 0", q, busy, done); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midburst_no_done cyc=%0d done=%b busy=%b exp=0 0", i, done, busy); end
    end
    load(8'h03);
    mode = 2'b01; rotate = 1'b1; start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0; mode = 2'b00;
    tick();
    n_checks++; if (q !== 8'h81 || busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_burst1 q=%h busy=%b exp=81 1", q, busy); end
    tick();
    n_checks++; if (q !== 8'hC0 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_burst2 q=%h done=%b busy=%b exp=c0 1 0", q, done, busy); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; rotate = 1'b0; sin_r = 1'b0; sin_l = 1'b0;
    d = 8'h00; start = 1'b0; len = 4'd0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_hold();
    test_shifts();
    test_burst(1'b0);
    test_burst(1'b1);
    test_boundaries();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
